// File: rtl/clkbuf_seq_pkg.sv
// Shared types and limits for the clock-buffer branch sequencer.
package clkbuf_seq_pkg;

  localparam int unsigned NMAX       = 8;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned PTR_W      = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // Next round-robin start position after index idx among n branches.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx,
                                               input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + PTR_W'(1);
  endfunction

endpackage

// File: rtl/clkbuf_seq_rr_pick.sv
// Combinational round-robin picker: lowest pending index at or after ptr, wrapping.
module clkbuf_seq_rr_pick
  import clkbuf_seq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     pending_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [PTR_W-1:0] idx_o
);

  localparam int unsigned SW = PTR_W + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to branch ptr.
    rot     = N'({pending_i, pending_i} >> ptr_i);
    valid_o = 1'b0;
    sum     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        sum     = {1'b0, ptr_i} + SW'(i);
      end
    end
    if (sum >= SW'(N)) sum = sum - SW'(N);
    idx_o = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/clkbuf_branch_sequencer.sv
// Staggers clock-gate enables of N clkbuf branches, one change per settle window.
module clkbuf_branch_sequencer
  import clkbuf_seq_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  output logic [N-1:0] EN,
  output logic [N-1:0] ACK,
  output logic         BUSY
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     en_q, en_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [N-1:0]     cur_q, cur_d;
  logic [N-1:0]     sel;
  logic [N-1:0]     pending;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;

  assign pending = REQ ^ en_q;

  clkbuf_seq_rr_pick #(.N(N)) u_pick (
    .pending_i (pending),
    .ptr_i     (ptr_q),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    en_d    = en_q;
    ack_d   = ack_q;
    cur_d   = cur_q;
    sel     = N'(1) << pick_idx;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          // Turning a branch off drops its ACK on the same edge as its EN.
          en_d    = en_q ^ sel;
          ack_d   = ack_q & ~sel;
          cur_d   = sel;
          cnt_d   = CNT_W'(SETTLE);
          ptr_d   = rr_next(pick_idx, N);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          ack_d   = ack_q | (cur_q & en_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      cur_q   <= cur_d;
    end
  end

  assign EN   = en_q;
  assign ACK  = ack_q;
  assign BUSY = (state_q == ST_SETTLE);

endmodule

// File: tb/tb_clkbuf_branch_sequencer.sv
// Directed bench: N=4/SETTLE=3 main instance plus an N=1/SETTLE=1 corner instance.
module tb_clkbuf_branch_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] req_m, en_m, ack_m;
  logic       busy_m;
  logic [0:0] req_s, en_s, ack_s;
  logic       busy_s;

  int checks;
  int errors;
  int cyc;

  logic [3:0] en_e, ack_e;

  clkbuf_branch_sequencer #(.N(4), .SETTLE(3)) u_dut (
    .CLK (clk), .RST (rst), .REQ (req_m), .EN (en_m), .ACK (ack_m), .BUSY (busy_m)
  );

  clkbuf_branch_sequencer #(.N(1), .SETTLE(1)) u_dut_s1 (
    .CLK (clk), .RST (rst), .REQ (req_s), .EN (en_s), .ACK (ack_s), .BUSY (busy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_main(input logic [3:0] ee, input logic [3:0] ae, input logic be);
    check($sformatf("en@%0d", cyc),   32'(en_m),   32'(ee));
    check($sformatf("ack@%0d", cyc),  32'(ack_m),  32'(ae));
    check($sformatf("busy@%0d", cyc), 32'(busy_m), 32'(be));
  endtask

  task automatic expect_s1(input logic ee, input logic ae, input logic be);
    check($sformatf("s1_en@%0d", cyc),   32'(en_s),   32'(ee));
    check($sformatf("s1_ack@%0d", cyc),  32'(ack_s),  32'(ae));
    check($sformatf("s1_busy@%0d", cyc), 32'(busy_s), 32'(be));
  endtask

  // Per-edge invariants on both instances, sampled on the falling edge.
  logic       mon_ok;
  logic       rst_prev;
  logic [3:0] en_m_prev;
  logic       busy_m_prev;
  logic [0:0] en_s_prev;
  logic       busy_s_prev;

  always @(negedge clk) begin
    if (mon_ok) begin
      check("ack_implies_en", 32'(ack_m & ~en_m), 32'd0);
      check("s1_ack_implies_en", 32'(ack_s & ~en_s), 32'd0);
      if (!rst_prev) begin
        check("one_en_change", 32'($countones(en_m ^ en_m_prev) <= 1), 32'd1);
        check("no_change_busy", 32'(busy_m_prev && (en_m != en_m_prev)), 32'd0);
        check("s1_no_change_busy", 32'(busy_s_prev && (en_s != en_s_prev)), 32'd0);
      end
    end
    mon_ok      = 1'b1;
    rst_prev    = rst;
    en_m_prev   = en_m;
    busy_m_prev = busy_m;
    en_s_prev   = en_s;
    busy_s_prev = busy_s;
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    mon_ok = 1'b0;
    rst    = 1'b1;
    req_m  = 4'b1111;
    req_s  = 1'b0;

    // Reset held for two edges with every branch requested.
    step(); expect_main(4'b0000, 4'b0000, 1'b0);
    step(); expect_main(4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // Staggered turn-on: EN[i] at 1+4i, ACK[i] at 4+4i.
    for (int c = 1; c <= 16; c++) begin
      go(c);
      for (int i = 0; i < 4; i++) begin
        en_e[i]  = (c >= 1 + 4 * i);
        ack_e[i] = (c >= 4 + 4 * i);
      end
      expect_main(en_e, ack_e, (c % 4) != 0);
    end

    // Staggered turn-off, ptr has wrapped 3->0 so branch 0 goes first.
    req_m = 4'b0000;
    for (int c = 17; c <= 32; c++) begin
      go(c);
      for (int i = 0; i < 4; i++) begin
        en_e[i]  = (c < 17 + 4 * i);
        ack_e[i] = (c < 17 + 4 * i);
      end
      expect_main(en_e, ack_e, (c % 4) != 0);
    end

    // Fairness: grant 2, then pending 0101 with ptr=3 -> 0 wins over 2.
    req_m = 4'b0100;
    go(33); expect_main(4'b0100, 4'b0000, 1'b1);
    req_m = 4'b0001;
    go(36); expect_main(4'b0100, 4'b0100, 1'b0);
    go(37); expect_main(4'b0101, 4'b0100, 1'b1);
    go(40); expect_main(4'b0101, 4'b0101, 1'b0);
    go(41); expect_main(4'b0001, 4'b0001, 1'b1);

    // Mid-settle withdraw of branch 1.
    go(44); expect_main(4'b0001, 4'b0001, 1'b0);
    req_m = 4'b0011;
    go(45); expect_main(4'b0011, 4'b0001, 1'b1);
    go(46); req_m = 4'b0001;
    go(48); expect_main(4'b0011, 4'b0011, 1'b0);
    go(49); expect_main(4'b0001, 4'b0001, 1'b1);
    go(52); expect_main(4'b0001, 4'b0001, 1'b0);

    // Reset while idle, then reset during the second turn-on.
    rst = 1'b1;
    go(53); expect_main(4'b0000, 4'b0000, 1'b0);
    rst   = 1'b0;
    req_m = 4'b1111;
    go(54); expect_main(4'b0001, 4'b0000, 1'b1);
    go(58); expect_main(4'b0011, 4'b0001, 1'b1);
    go(59); expect_main(4'b0011, 4'b0001, 1'b1);
    rst = 1'b1;
    go(60); expect_main(4'b0000, 4'b0000, 1'b0);
    rst   = 1'b0;
    req_m = 4'b0000;
    go(61); expect_main(4'b0000, 4'b0000, 1'b0);

    // N=1, SETTLE=1 corner: one-cycle settle; request during settle waits for idle.
    expect_s1(1'b0, 1'b0, 1'b0);
    req_s = 1'b1;
    go(62); expect_s1(1'b1, 1'b0, 1'b1);
    go(63); expect_s1(1'b1, 1'b1, 1'b0);
    req_s = 1'b0;
    go(64); expect_s1(1'b0, 1'b0, 1'b1);
    req_s = 1'b1;
    go(65); expect_s1(1'b0, 1'b0, 1'b0);
    go(66); expect_s1(1'b1, 1'b0, 1'b1);
    go(68); expect_s1(1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
